bcd_code_converter_pipe: RTL

//   Parametrised, registered successor to our 4-input BCD code-conversion logic.

---
 rtl/bcd_code_converter_pipe.sv | 112 +++++++++++
 1 files changed

// File: rtl/bcd_code_converter_pipe.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | bcd_code_converter_pipe                                                    |
// |   Registered BCD -> excess-3 / Gray / 2421 / 9s-complement converter with  |
// |   a one-stage valid/ready pipe, per-lane invalid flags and an error count. |
// |   Rev 1.0                                                                  |
// +----------------------------------------------------------------------------+
module bcd_code_converter_pipe #(
  parameter int DIGITS = 4,
  parameter int CNT_W  = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [1:0]            mode,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [4*DIGITS-1:0]   in_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [4*DIGITS-1:0]   out_data,
  output logic [DIGITS-1:0]     out_err,
  output logic [CNT_W-1:0]      err_cnt,
  input  logic                  clr_cnt
);

  localparam int         W       = 4 * DIGITS;
  localparam logic [1:0] M_XS3   = 2'b00;
  localparam logic [1:0] M_GRAY  = 2'b01;
  localparam logic [1:0] M_2421  = 2'b10;

  logic [W-1:0]      conv_data;
  logic [DIGITS-1:0] conv_err;
  logic              accept;

  logic              out_valid_d, out_valid_q;
  logic [W-1:0]      out_data_d,  out_data_q;
  logic [DIGITS-1:0] out_err_d,   out_err_q;
  logic [CNT_W-1:0]  err_cnt_d,   err_cnt_q;

  // Conversion happens on the incoming word, so the mode is effectively
  // captured together with the data at accept time.
  generate
    for (genvar i = 0; i < DIGITS; i++) begin : g_lane
      logic [3:0] digit;
      logic [3:0] code;

      assign digit = in_data[4*i +: 4];

      always_comb begin
        code = 4'h0;
        if (digit <= 4'd9) begin
          case (mode)
            M_XS3:   code = digit + 4'd3;
            M_GRAY:  code = digit ^ {1'b0, digit[3:1]};
            M_2421:  code = (digit < 4'd5) ? digit : digit + 4'd6;
            default: code = 4'd9 - digit;
          endcase
        end
      end

      assign conv_data[4*i +: 4] = code;
      assign conv_err[i]         = (digit > 4'd9);
    end
  endgenerate

  assign in_ready = ~out_valid_q | out_ready;
  assign accept   = in_valid & in_ready;

  always_comb begin
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_err_d   = out_err_q;
    if (accept) begin
      out_valid_d = 1'b1;
      out_data_d  = conv_data;
      out_err_d   = conv_err;
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  // Clear has priority; counting stops at all-ones.
  always_comb begin
    err_cnt_d = err_cnt_q;
    if (clr_cnt) begin
      err_cnt_d = '0;
    end else if (accept && (|conv_err) && (err_cnt_q != {CNT_W{1'b1}})) begin
      err_cnt_d = err_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_err_q   <= '0;
      err_cnt_q   <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_err_q   <= out_err_d;
      err_cnt_q   <= err_cnt_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_err   = out_err_q;
  assign err_cnt   = err_cnt_q;

endmodule
`default_nettype wire
